rr_lock_arbiter: RTL and testbench

- Registered round-robin arbiter that shares one downstream resource (bus port, shared buffer write port) between N requesters.
- A granted requester keeps ownership for a multi-cycle transaction until it signals last, drops its request, or hits a hold-time limit.
- Pointer-based fairness; zero-bubble handover between owners.
- Sits in front of any shared datapath resource that currently uses a combinational fixed-priority grant.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rr_lock_arbiter.sv | 99 +++++++++
 tb/tb_rr_lock_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin lock arbiter.
package arb_pkg;

  localparam int ARB_N        = 4;
  localparam int ARB_MAX_HOLD = 8;

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_e;

  function automatic logic [4:0] onehot2bin(input logic [31:0] oh);
    logic [4:0] b;
    b = '0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) b = b | 5'(i);
    return b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin one-hot pick: doubled request vector, kill chain
// armed at the priority pointer position.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] ptr_i,
  output logic [N-1:0] winner_o
);

  logic [2*N-1:0] dreq;
  logic [2*N-1:0] dptr;
  logic [2*N-1:0] dwin;
  logic           arm;
  logic           kill;

  always_comb begin
    dreq = {req_i, req_i};
    dptr = {{N{1'b0}}, ptr_i};
    dwin = '0;
    arm  = 1'b0;
    kill = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      if (dptr[i]) arm = 1'b1;
      if (arm && !kill && dreq[i]) begin
        dwin[i] = 1'b1;
        kill    = 1'b1;
      end
    end
    winner_o = dwin[N-1:0] | dwin[2*N-1:N];
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Registered round-robin arbiter with transaction locking
// and a per-ownership hold-time limit.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = ARB_N,
  parameter  int MAX_HOLD = ARB_MAX_HOLD,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           hold_expired
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_e     state_q;
  logic [N-1:0]   gnt_q;
  logic [N-1:0]   ptr_q;
  logic [CW-1:0]  hold_cnt_q;
  logic [IDW-1:0] gnt_id_q;
  logic           hexp_q;

  logic           own_req;
  logic           own_last;
  logic           at_cap;
  logic           rel;
  logic [N-1:0]   rot_ptr;
  logic [N-1:0]   pick_req;
  logic [N-1:0]   pick_ptr;
  logic [N-1:0]   win;
  logic [IDW-1:0] win_id;

  always_comb begin
    own_req  = |(gnt_q & req);
    own_last = |(gnt_q & last);
    at_cap   = (hold_cnt_q == CW'(MAX_HOLD - 1));
    rel      = (state_q == OWN) &&
               (!own_req || own_last || at_cap);
    rot_ptr  = {gnt_q[N-2:0], gnt_q[N-1]};
    // On release the owner is masked out and search starts after it.
    pick_req = rel ? (req & ~gnt_q) : req;
    pick_ptr = rel ? rot_ptr : ptr_q;
    win_id   = IDW'(onehot2bin(32'(win)));
  end

  rr_pick #(.N(N)) u_pick (
    .req_i    (pick_req),
    .ptr_i    (pick_ptr),
    .winner_o (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_q      <= N'(1);
      hold_cnt_q <= '0;
      gnt_id_q   <= '0;
      hexp_q     <= 1'b0;
    end else begin
      hexp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_q    <= OWN;
            gnt_q      <= win;
            gnt_id_q   <= win_id;
            hold_cnt_q <= '0;
          end
        end
        OWN: begin
          if (rel) begin
            ptr_q      <= rot_ptr;
            gnt_q      <= win;
            gnt_id_q   <= win_id;
            hold_cnt_q <= '0;
            hexp_q     <= own_req && !own_last && at_cap;
            state_q    <= (|win) ? OWN : IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign gnt_valid    = |gnt_q;
  assign gnt_id       = gnt_id_q;
  assign hold_expired = hexp_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed table-driven bench for rr_lock_arbiter.
module tb_rr_lock_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] egnt;
    logic [1:0] eid;
    logic       ehexp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req, last, gnt;
  logic       gnt_valid, hold_expired;
  logic [1:0] gnt_id;
  logic [3:0] req1, last1, gnt1;
  logic       gnt_valid1, hold_expired1;
  logic [1:0] gnt_id1;

  int   nvec;
  int   nbad;
  vec_t vq[$];

  rr_lock_arbiter #(.N(4), .MAX_HOLD(8)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .last         (last),
    .gnt          (gnt),
    .gnt_valid    (gnt_valid),
    .gnt_id       (gnt_id),
    .hold_expired (hold_expired)
  );

  rr_lock_arbiter #(.N(4), .MAX_HOLD(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req1),
    .last         (last1),
    .gnt          (gnt1),
    .gnt_valid    (gnt_valid1),
    .gnt_id       (gnt_id1),
    .hold_expired (hold_expired1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [3:0] g, input logic v,
                     input logic [1:0] id, input logic h,
                     input logic [3:0] eg, input logic [1:0] eid,
                     input logic eh);
    nvec++;
    if (g !== eg || v !== (|eg) || id !== eid || h !== eh) begin
      nbad++;
      $display("FAIL %s: got gnt=%b valid=%b id=%0d hexp=%b, want gnt=%b valid=%b id=%0d hexp=%b",
               nm, g, v, id, h, eg, |eg, eid, eh);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq,
                     input logic [3:0] ls, input logic [3:0] eg,
                     input logic [1:0] eid, input logic eh);
    vec_t v;
    v.rst = r; v.req = rq; v.last = ls;
    v.egnt = eg; v.eid = eid; v.ehexp = eh;
    vq.push_back(v);
  endtask

  initial begin
    logic [3:0] oh;
    nvec  = 0;
    nbad  = 0;
    rst_n = 1'b0;
    req   = '0; last  = '0;
    req1  = '0; last1 = '0;

    // basic grant, drop-handover, foreign last, last-handover, idle
    add(0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 0);
    add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
    add(0, 4'b0110, 4'b1010, 4'b0100, 2'd2, 0);
    add(0, 4'b0110, 4'b0100, 4'b0010, 2'd1, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
    // full rotation, each owner held 3 cycles, no bubbles
    add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0);
    for (int o = 0; o < 4; o++) begin
      oh = 4'b0001 << o;
      add(0, 4'b1111, 4'b0000, oh, 2'(o), 0);
      add(0, 4'b1111, 4'b0000, oh, 2'(o), 0);
      add(0, 4'b1111, oh, 4'b0001 << ((o + 1) % 4),
          2'((o + 1) % 4), 0);
    end
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
    // hold limit expiry with a lone requester
    for (int i = 0; i < 8; i++)
      add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0);
    add(0, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1);
    add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0);
    // drop at the limit: no expiry pulse
    for (int i = 0; i < 7; i++)
      add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
    // last at the limit: no expiry pulse
    add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0);
    for (int i = 0; i < 7; i++)
      add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset", gnt, gnt_valid, gnt_id, hold_expired,
        4'b0000, 2'd0, 0);
    chk("reset1", gnt1, gnt_valid1, gnt_id1, hold_expired1,
        4'b0000, 2'd0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = !vq[i].rst;
      req   = vq[i].req;
      last  = vq[i].last;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), gnt, gnt_valid, gnt_id,
          hold_expired, vq[i].egnt, vq[i].eid, vq[i].ehexp);
    end

    // asynchronous reset while requester 3 owns with hold_cnt=5
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1000;
    last  = 4'b0000;
    repeat (6) @(posedge clk);
    #1;
    chk("own3", gnt, gnt_valid, gnt_id, hold_expired,
        4'b1000, 2'd3, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", gnt, gnt_valid, gnt_id, hold_expired,
        4'b0000, 2'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1001;
    @(posedge clk);
    #1;
    chk("post_rst", gnt, gnt_valid, gnt_id, hold_expired,
        4'b0001, 2'd0, 0);
    @(negedge clk);
    req = 4'b0000;

    // MAX_HOLD=1: pure per-cycle round robin
    req1 = 4'b1011;
    @(posedge clk); #1;
    chk("mh1_c1", gnt1, gnt_valid1, gnt_id1, hold_expired1,
        4'b0001, 2'd0, 0);
    @(posedge clk); #1;
    chk("mh1_c2", gnt1, gnt_valid1, gnt_id1, hold_expired1,
        4'b0010, 2'd1, 1);
    @(posedge clk); #1;
    chk("mh1_c3", gnt1, gnt_valid1, gnt_id1, hold_expired1,
        4'b1000, 2'd3, 1);
    @(posedge clk); #1;
    chk("mh1_c4", gnt1, gnt_valid1, gnt_id1, hold_expired1,
        4'b0001, 2'd0, 1);
    req1 = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
